// File: rtl/serial_pkg.sv
// Shared definitions for the serial frame transmitter: FSM state encoding and line levels.
package serial_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        START  = ST_START,
        DATA   = ST_DATA,
        PARITY = ST_PARITY,
        STOP   = ST_STOP
    } state_t;

    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/frame_bit_counter.sv
// Loadable down-counter of data bits left in a frame; tc flags the final data bit.
module frame_bit_counter #(
    parameter int CW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          dec,
    output logic          tc
);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Decrement stops at zero so the count can never wrap within a frame.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_value;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == '0);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, WIDTH data bits, optional even parity, stop bit.
module serial_frame_tx #(
    parameter int WIDTH     = 4,
    parameter int PARITY_EN = 1,
    parameter int LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             busy,
    output logic             frame_done
);

    import serial_pkg::*;

    localparam int CW = $clog2(WIDTH + 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic             parity_q, parity_d;
    logic             sout_q, sout_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;

    logic             cnt_clear;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_tc;
    logic             accept;
    logic             next_bit;
    logic [WIDTH-1:0] shifted;

    frame_bit_counter #(.CW(CW)) u_bit_counter (
        .clk        (clk),
        .rst        (rst),
        .clear      (cnt_clear),
        .load       (cnt_load),
        .load_value (CW'(WIDTH - 1)),
        .dec        (cnt_dec),
        .tc         (cnt_tc)
    );

    // Ready is masked by rst so it reads low during reset yet is high on the first edge after release.
    assign din_ready = ((state_q == IDLE) || (state_q == STOP)) && !rst;
    assign accept    = din_valid && din_ready;

    assign next_bit = (LSB_FIRST != 0) ? shift_q[0] : shift_q[WIDTH-1];
    assign shifted  = (LSB_FIRST != 0) ? {1'b0, shift_q[WIDTH-1:1]}
                                       : {shift_q[WIDTH-2:0], 1'b0};

    // Each state names the bit currently on sout; outputs are computed for the next state.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        parity_d     = parity_q;
        sout_d       = IDLE_LEVEL;
        busy_d       = 1'b1;
        frame_done_d = 1'b0;
        cnt_clear    = 1'b0;
        cnt_load     = 1'b0;
        cnt_dec      = 1'b0;

        case (state_q)
            IDLE, STOP: begin
                if (accept) begin
                    state_d   = START;
                    shift_d   = din;
                    parity_d  = ^din;
                    sout_d    = START_LEVEL;
                    cnt_clear = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            START: begin
                state_d  = DATA;
                sout_d   = next_bit;
                shift_d  = shifted;
                cnt_load = 1'b1;
            end
            DATA: begin
                if (cnt_tc) begin
                    if (PARITY_EN != 0) begin
                        state_d = PARITY;
                        sout_d  = parity_q;
                    end else begin
                        state_d      = STOP;
                        sout_d       = STOP_LEVEL;
                        frame_done_d = 1'b1;
                    end
                end else begin
                    sout_d  = next_bit;
                    shift_d = shifted;
                    cnt_dec = 1'b1;
                end
            end
            PARITY: begin
                state_d      = STOP;
                sout_d       = STOP_LEVEL;
                frame_done_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            sout_q       <= IDLE_LEVEL;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            parity_q     <= parity_d;
            sout_q       <= sout_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign sout       = sout_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: two parameterisations checked every cycle against a queue-of-frame-bits model.
module tb_serial_frame_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din_a, din_b;
    logic       valid_a, valid_b;
    logic       ready_a, ready_b;
    logic       sout_a, sout_b;
    logic       busy_a, busy_b;
    logic       done_a, done_b;

    int errors = 0;
    int checks = 0;

    // Model entries are {kind, bit}: kind 0 start, 1 data, 2 parity, 3 stop.
    logic [2:0] qa[$];
    logic [2:0] qb[$];
    logic       last_sout_a, last_sout_b;
    logic [3:0] chain_a, chain_b;

    logic exp34[7] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic exp36[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic exp37[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

    always #5 clk = ~clk;

    serial_frame_tx #(.WIDTH(4), .PARITY_EN(1), .LSB_FIRST(1)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .din        (din_a),
        .din_valid  (valid_a),
        .din_ready  (ready_a),
        .sout       (sout_a),
        .busy       (busy_a),
        .frame_done (done_a)
    );

    serial_frame_tx #(.WIDTH(4), .PARITY_EN(0), .LSB_FIRST(0)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .din        (din_b),
        .din_valid  (valid_b),
        .din_ready  (ready_b),
        .sout       (sout_b),
        .busy       (busy_b),
        .frame_done (done_b)
    );

    task automatic pushFrame(input bit which_b, input logic [3:0] w, input bit par_en, input bit lsb_first);
        logic [2:0] f[$];
        int ones;
        logic b;
        ones = 0;
        f.push_back({2'd0, 1'b0});
        for (int i = 0; i < 4; i++) begin
            b = lsb_first ? w[i] : w[3-i];
            ones += int'(b);
            f.push_back({2'd1, b});
        end
        if (par_en) f.push_back({2'd2, 1'(ones % 2)});
        f.push_back({2'd3, 1'b1});
        foreach (f[i]) begin
            if (which_b) qb.push_back(f[i]);
            else         qa.push_back(f[i]);
        end
    endtask

    task automatic checkOutput(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkWord(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic checkAll();
        logic es, eb, ed, er;
        es = (qa.size() == 0) ? 1'b1 : qa[0][0];
        eb = (qa.size() != 0);
        ed = (qa.size() != 0) && (qa[0][2:1] == 2'd3);
        er = !rst && (qa.size() <= 1);
        checkOutput("a_sout", sout_a, es);
        checkOutput("a_busy", busy_a, eb);
        checkOutput("a_frame_done", done_a, ed);
        checkOutput("a_din_ready", ready_a, er);
        es = (qb.size() == 0) ? 1'b1 : qb[0][0];
        eb = (qb.size() != 0);
        ed = (qb.size() != 0) && (qb[0][2:1] == 2'd3);
        er = !rst && (qb.size() <= 1);
        checkOutput("b_sout", sout_b, es);
        checkOutput("b_busy", busy_b, eb);
        checkOutput("b_frame_done", done_b, ed);
        checkOutput("b_din_ready", ready_b, er);
        last_sout_a = sout_a;
        last_sout_b = sout_b;
    endtask

    // One clock: decide acceptance from the model, advance the model, then check both DUTs.
    task automatic applyStimulus();
        bit acc_a, acc_b;
        logic [3:0] wa, wb;
        acc_a = valid_a && !rst && (qa.size() <= 1);
        acc_b = valid_b && !rst && (qb.size() <= 1);
        wa = din_a;
        wb = din_b;
        @(posedge clk);
        if (rst) begin
            qa.delete();
            qb.delete();
        end else begin
            if (qa.size() > 0 && qa[0][2:1] == 2'd1) chain_a = {last_sout_a, chain_a[3:1]};
            if (qb.size() > 0 && qb[0][2:1] == 2'd1) chain_b = {chain_b[2:0], last_sout_b};
            if (qa.size() > 0) void'(qa.pop_front());
            if (qb.size() > 0) void'(qb.pop_front());
            if (acc_a) pushFrame(1'b0, wa, 1'b1, 1'b1);
            if (acc_b) pushFrame(1'b1, wb, 1'b0, 1'b0);
        end
        #1;
        checkAll();
    endtask

    task automatic setResetMidCycle(input logic level);
        #2;
        rst = level;
        if (level) begin
            qa.delete();
            qb.delete();
        end
        #1;
        checkAll();
    endtask

    initial begin
        rst = 1'b1;
        valid_a = 1'b0; valid_b = 1'b0;
        din_a = 4'h0;   din_b = 4'h0;
        chain_a = 4'h0; chain_b = 4'h0;
        last_sout_a = 1'b1; last_sout_b = 1'b1;

        for (int i = 0; i < 3; i++) applyStimulus();
        setResetMidCycle(1'b0);
        applyStimulus();

        $display("[TB] single frame, LSB first with parity");
        chain_a = 4'h0;
        din_a = 4'b1011; valid_a = 1'b1;
        applyStimulus();
        valid_a = 1'b0; din_a = 4'b0101;
        for (int i = 0; i < 7; i++) begin
            checkOutput("req34_sout", sout_a, exp34[i]);
            checkOutput("req34_done", done_a, (i == 6));
            applyStimulus();
        end
        checkWord("req38_chain_a", chain_a, 4'b1011);
        checkOutput("req34_idle_sout", sout_a, 1'b1);

        $display("[TB] back-to-back frames");
        din_a = 4'b1011; valid_a = 1'b1;
        applyStimulus();
        din_a = 4'b0000;
        for (int i = 0; i < 7; i++) applyStimulus();
        checkOutput("req35_second_start", sout_a, 1'b0);
        checkOutput("req35_busy", busy_a, 1'b1);
        valid_a = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus();
        checkOutput("req35_stop_done", done_a, 1'b1);
        checkOutput("req35_stop_sout", sout_a, 1'b1);
        applyStimulus();
        checkOutput("req35_idle_busy", busy_a, 1'b0);

        $display("[TB] no parity, MSB first");
        chain_b = 4'h0;
        din_b = 4'b1000; valid_b = 1'b1;
        applyStimulus();
        valid_b = 1'b0; din_b = 4'b0111;
        for (int i = 0; i < 6; i++) begin
            checkOutput("req36_sout", sout_b, exp36[i]);
            applyStimulus();
        end
        checkWord("req38_chain_b", chain_b, 4'b1000);

        $display("[TB] abort mid-frame");
        din_a = 4'b1011; valid_a = 1'b1;
        din_b = 4'b1111; valid_b = 1'b1;
        applyStimulus();
        valid_a = 1'b0; valid_b = 1'b0;
        applyStimulus();
        applyStimulus();
        setResetMidCycle(1'b1);
        checkOutput("req28_async_sout", sout_a, 1'b1);
        for (int i = 0; i < 3; i++) applyStimulus();
        setResetMidCycle(1'b0);
        checkOutput("req33_ready_after", ready_a, 1'b1);
        din_a = 4'b0110; valid_a = 1'b1;
        applyStimulus();
        valid_a = 1'b0;
        for (int i = 0; i < 7; i++) begin
            checkOutput("req37_sout", sout_a, exp37[i]);
            applyStimulus();
        end

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            valid_a = ($urandom_range(0, 9) < 7);
            valid_b = ($urandom_range(0, 9) < 7);
            din_a = 4'($urandom);
            din_b = 4'($urandom);
            if (i == 200) setResetMidCycle(1'b1);
            if (i == 203) setResetMidCycle(1'b0);
            applyStimulus();
        end
        valid_a = 1'b0; valid_b = 1'b0;
        for (int i = 0; i < 10; i++) applyStimulus();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_frame_tx.md
SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

Interface
REQ-001 Parameter WIDTH, default 4, data bits per frame (legal 2..16).
REQ-002 Parameter PARITY_EN, default 1; 1 inserts an even-parity bit, 0 omits it.
REQ-003 Parameter LSB_FIRST, default 1; 1 sends din[0] first, 0 sends din[WIDTH-1] first.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 din  input  WIDTH  parallel word to serialize.
REQ-007 din_valid  input  1  din holds a word offered for transmission.
REQ-008 din_ready  output  1  block accepts din this cycle.
REQ-009 sout  output  1  registered serial line; feeds a downstream serial-in shift register's sin.
REQ-010 busy  output  1  frame in progress.
REQ-011 frame_done  output  1  one-cycle pulse marking the last bit of a frame.

Function
REQ-012 Frame SHALL be: start bit (0), WIDTH data bits, parity bit if PARITY_EN, stop bit (1); exactly one bit per clk.
REQ-013 Frame length SHALL be FLEN = WIDTH + 2 + PARITY_EN cycles, e.g. 7 for WIDTH=4, PARITY_EN=1.
REQ-014 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-015 Transitions: IDLE->START on accept; START->DATA; DATA->DATA until WIDTH bits sent, then PARITY if PARITY_EN, else STOP; PARITY->STOP; STOP->START on accept, else IDLE.
REQ-016 Accept SHALL occur when din_valid && din_ready at a rising edge; din is captured into an internal shift register on that edge.
REQ-017 din_ready SHALL be 1 in IDLE and STOP, and 0 in all other states.
REQ-018 The start bit SHALL appear on sout in the cycle immediately after accept (latency 1).
REQ-019 Accept during STOP SHALL give back-to-back frames with no idle cycle between stop and next start.
REQ-020 sout SHALL be 1 in IDLE (line idle high).
REQ-021 Parity bit SHALL equal XOR of the captured word, so that data plus parity has an even count of ones.
REQ-022 The data bit counter SHALL be ceil(log2(WIDTH+1)) bits wide; it clears on START and never wraps mid-frame.
REQ-023 busy SHALL be 1 in every state except IDLE.
REQ-024 frame_done SHALL be 1 exactly in the cycle sout carries the stop bit.
REQ-025 din_valid deasserted or din changing outside an accept edge SHALL have no effect.
REQ-026 din_valid held high continuously SHALL yield contiguous frames, each carrying the word presented at its accept edge.

Reset
REQ-027 While rst=1: state=IDLE, sout=1, busy=0, frame_done=0, din_ready=0, shift register and counter=0.
REQ-028 rst asserted mid-frame SHALL abort the frame immediately, asynchronously forcing sout=1; no partial frame resumes.
REQ-029 First accept SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-030 Package serial_pkg SHALL hold the state encoding localparams (IDLE..STOP) and the line levels IDLE_LEVEL=1, START_LEVEL=0, STOP_LEVEL=1.
REQ-031 One sub-module SHALL be used: frame_bit_counter, a loadable down-counter with a terminal-count flag that drives the DATA->PARITY/STOP decision.
REQ-032 No other hierarchy; the parity XOR and the shift register SHALL be inline.

Verification
REQ-033 Reset: hold rst for 3 cycles mid-stream -> sout=1, busy=0, din_ready=0, frame_done=0 throughout; after release, din_ready=1.
REQ-034 Single frame, WIDTH=4, PARITY_EN=1, LSB_FIRST=1: accept din=4'b1011 at cycle 0 -> sout over cycles 1..7 = 0,1,1,0,1,1,1; frame_done=1 only at cycle 7; then IDLE with sout=1.
REQ-035 Back-to-back: din_valid held high with 4'b1011 then 4'b0000 -> second start bit at cycle 8, second frame data/parity = 0,0,0,0,0, stop at cycle 14.
REQ-036 PARITY_EN=0, LSB_FIRST=0, din=4'b1000 -> sout cycles 1..6 = 0,1,0,0,0,1.
REQ-037 Abort: assert rst at cycle 3 of a frame, release at cycle 5, then accept 4'b0110 -> clean full frame with correct parity 0; no bits of the aborted word appear.
REQ-038 Chain: sout drives a 4-bit serial-in shift register; after a frame with din=4'b1011 and no further shifts beyond the 4 data bits -> its parallel output matches the bit ordering set by LSB_FIRST.
